fft_sequencer: RTL and testbench

Control block that sequences the radix-2 in-place FFT datapath: it drives the bit-reversed load of the sample registers and issues every butterfly, one per cycle, over all LOG_2_WIDTH stages. For each butterfly it supplies the operand pair indices and the twiddle index. It waits out the butterfly pipeline latency between stages and signals completion with a held `done` that the consumer must acknowledge. It sits between the host/start logic and the butterfly register file, twiddle muxes and arithmetic.

---
 rtl/fft_seq_if.sv | 31 +++
 rtl/fft_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_if.sv
// Handshake and index bus between the FFT sequencer (slave side) and the host /
// butterfly register file (master side).
interface fft_seq_if #(
  parameter int LOG_2_WIDTH = 6
);
  logic                     start;
  logic                     hold;
  logic                     done_ack;
  logic                     busy;
  logic                     load_en;
  logic [LOG_2_WIDTH-1:0]   load_src;
  logic [LOG_2_WIDTH-1:0]   load_dst;
  logic                     bf_valid;
  logic [LOG_2_WIDTH-1:0]   stage;
  logic [LOG_2_WIDTH-1:0]   idx_a;
  logic [LOG_2_WIDTH-1:0]   idx_b;
  logic [LOG_2_WIDTH-2:0]   tw_idx;
  logic                     done;

  modport master (
    output start, hold, done_ack,
    input  busy, load_en, load_src, load_dst, bf_valid, stage,
           idx_a, idx_b, tw_idx, done
  );

  modport slave (
    input  start, hold, done_ack,
    output busy, load_en, load_src, load_dst, bf_valid, stage,
           idx_a, idx_b, tw_idx, done
  );
endinterface

// File: rtl/fft_sequencer.sv
// Radix-2 in-place FFT control: sample load, per-stage butterfly issue, drain and
// acknowledged completion. Define FFT_SEQ_BITREV_EN to bit-reverse load addresses.
module fft_sequencer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int BF_LAT      = 2
) (
  input  logic     clk,
  input  logic     rst,
  fft_seq_if.slave bus
);

  localparam int TW_W = LOG_2_WIDTH - 1;
  localparam logic [LOG_2_WIDTH-1:0] LOAD_LAST  = LOG_2_WIDTH'(D_WIDTH - 1);
  localparam logic [LOG_2_WIDTH-1:0] RUN_LAST   = LOG_2_WIDTH'(D_WIDTH / 2 - 1);
  localparam logic [LOG_2_WIDTH-1:0] STAGE_LAST = LOG_2_WIDTH'(LOG_2_WIDTH - 1);
  localparam logic [LOG_2_WIDTH-1:0] DRAIN_LAST = LOG_2_WIDTH'((BF_LAT > 0) ? BF_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [LOG_2_WIDTH-1:0] a;
    logic [LOG_2_WIDTH-1:0] b;
    logic [TW_W-1:0]        tw;
  } bf_idx_t;

  // Operand pair and twiddle for butterfly k of stage s.
  function automatic bf_idx_t bf_index(input logic [LOG_2_WIDTH-1:0] k,
                                       input logic [LOG_2_WIDTH-1:0] s);
    logic [LOG_2_WIDTH-1:0] half;
    logic [LOG_2_WIDTH-1:0] pos;
    logic [LOG_2_WIDTH-1:0] group;
    bf_idx_t                r;
    half  = LOG_2_WIDTH'(1) << s;
    pos   = k & (half - 1'b1);
    group = k >> s;
    r.a   = (group << (s + 1'b1)) | pos;
    r.b   = r.a + half;
    r.tw  = TW_W'(pos << (LOG_2_WIDTH - 1 - int'(s)));
    return r;
  endfunction

  function automatic logic [LOG_2_WIDTH-1:0] load_map(input logic [LOG_2_WIDTH-1:0] src);
    logic [LOG_2_WIDTH-1:0] r;
`ifdef FFT_SEQ_BITREV_EN
    for (int i = 0; i < LOG_2_WIDTH; i++) r[i] = src[LOG_2_WIDTH-1-i];
`else
    r = src;
`endif
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [LOG_2_WIDTH-1:0] cnt_q, cnt_d;
  logic [LOG_2_WIDTH-1:0] stage_q, stage_d;
  logic [LOG_2_WIDTH-1:0] load_src_q, load_dst_q;
  bf_idx_t                bf_q, bf_d;

  // NOTE: state updates on the falling edge to line up with the butterfly register
  // file; sequential blocks use non-blocking assignments only.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      LOAD: begin
        if (!bus.hold) begin
          if (cnt_q == LOAD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (cnt_q == RUN_LAST) begin
            cnt_d = '0;
            // With no pipeline latency the next stage follows back to back.
            if (BF_LAT > 0)                state_d = DRAIN;
            else if (stage_q == STAGE_LAST) state_d = DONE;
            else                           stage_d = stage_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.done_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bf_d = bf_index(cnt_d, stage_d);

  // Index outputs are registered from next-state counters so they are valid in the
  // same cycle the combinational strobe rises.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      stage_q    <= '0;
      load_src_q <= '0;
      load_dst_q <= '0;
      bf_q       <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      if (state_d == LOAD) begin
        load_src_q <= cnt_d;
        load_dst_q <= load_map(cnt_d);
      end
      if (state_d == RUN) bf_q <= bf_d;
    end
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.load_en  = 1'b0;
    bus.bf_valid = 1'b0;
    bus.done     = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.busy    = 1'b1;
        bus.load_en = !bus.hold;
      end
      RUN: begin
        bus.busy     = 1'b1;
        bus.bf_valid = !bus.hold;
      end
      DRAIN:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_src = load_src_q;
  assign bus.load_dst = load_dst_q;
  assign bus.stage    = stage_q;
  assign bus.idx_a    = bf_q.a;
  assign bus.idx_b    = bf_q.b;
  assign bus.tw_idx   = bf_q.tw;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: reset values, full transform timing, index and
// load-address tables, hold, ignored starts, done handshake and mid-run reset.
module tb_fft_sequencer;
  localparam int N   = 64;
  localparam int L   = 6;
  localparam int BL  = 2;
  localparam int NOM = 268;

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } idx_vec_t;

  typedef struct {
    int src;
    int dst;
  } ld_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_seq_if #(.LOG_2_WIDTH(L)) bus();

  fft_sequencer #(.D_WIDTH(N), .LOG_2_WIDTH(L), .BF_LAT(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int rec_a  [L][N/2];
  int rec_b  [L][N/2];
  int rec_tw [L][N/2];
  int kc     [L];
  int seen   [L][N];
  int ld_dst [N];

  idx_vec_t iv[9];
  ld_vec_t  lv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},     32'(bus.busy),     0);
    check({tag, " done"},     32'(bus.done),     0);
    check({tag, " load_en"},  32'(bus.load_en),  0);
    check({tag, " bf_valid"}, 32'(bus.bf_valid), 0);
    check({tag, " load_src"}, 32'(bus.load_src), 0);
    check({tag, " load_dst"}, 32'(bus.load_dst), 0);
    check({tag, " stage"},    32'(bus.stage),    0);
    check({tag, " idx_a"},    32'(bus.idx_a),    0);
    check({tag, " idx_b"},    32'(bus.idx_b),    0);
    check({tag, " tw_idx"},   32'(bus.tw_idx),   0);
  endtask

  // Starts a transform and follows it to done, optionally holding 3 cycles at
  // s=3,k=10 (a=18) and pulsing start once mid-run.
  task automatic run_transform(input bit do_hold, input bit start_mid,
                               output int busy_cyc, output int loads, output int bfs,
                               output int k10_issues, output bit got_done);
    int hold_left;
    int s;
    busy_cyc = 0; loads = 0; bfs = 0; k10_issues = 0; got_done = 1'b0;
    hold_left = do_hold ? 3 : 0;
    for (int i = 0; i < L; i++) begin
      kc[i] = 0;
      for (int j = 0; j < N; j++) seen[i][j] = 0;
    end
    for (int j = 0; j < N; j++) ld_dst[j] = -1;

    @(posedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      bus.start = start_mid && (c == 150);
      if (hold_left > 0 && bus.stage == 3 && bus.idx_a == 18) begin
        bus.hold = 1'b1;
        hold_left--;
      end else begin
        bus.hold = 1'b0;
      end
      #1;
      if (c == 0) begin
        check("first load_en", 32'(bus.load_en), 1);
        check("first load_src", 32'(bus.load_src), 0);
      end
      if (bus.hold) begin
        check("hold bf_valid", 32'(bus.bf_valid), 0);
        check("hold idx_a", 32'(bus.idx_a), 18);
        check("hold idx_b", 32'(bus.idx_b), 26);
        check("hold tw_idx", 32'(bus.tw_idx), 8);
      end
      if (bus.load_en) begin
        loads++;
        ld_dst[bus.load_src] = int'(bus.load_dst);
      end
      if (bus.bf_valid) begin
        bfs++;
        s = int'(bus.stage);
        if (s < L) begin
          if (kc[s] < N/2) begin
            rec_a[s][kc[s]]  = int'(bus.idx_a);
            rec_b[s][kc[s]]  = int'(bus.idx_b);
            rec_tw[s][kc[s]] = int'(bus.tw_idx);
          end
          kc[s]++;
          seen[s][bus.idx_a]++;
          seen[s][bus.idx_b]++;
          if (s == 3 && bus.idx_a == 18) k10_issues++;
        end
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic ack_done();
    @(posedge clk);
    bus.done_ack = 1'b1;
    #1;
    check("done before ack edge", 32'(bus.done), 1);
    @(posedge clk);
    bus.done_ack = 1'b0;
    #1;
    check("done after ack", 32'(bus.done), 0);
    check("busy after ack", 32'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  busy_cyc, loads, bfs, k10;
    bit  got_done;
    int  bad;
    bit  reached;

    iv[0] = '{s: 0, k: 1,  a: 2,  b: 3,  tw: 0};
    iv[1] = '{s: 2, k: 5,  a: 9,  b: 13, tw: 8};
    iv[2] = '{s: 5, k: 31, a: 31, b: 63, tw: 31};
    iv[3] = '{s: 0, k: 0,  a: 0,  b: 1,  tw: 0};
    iv[4] = '{s: 0, k: 31, a: 62, b: 63, tw: 0};
    iv[5] = '{s: 1, k: 3,  a: 5,  b: 7,  tw: 16};
    iv[6] = '{s: 3, k: 10, a: 18, b: 26, tw: 8};
    iv[7] = '{s: 4, k: 20, a: 36, b: 52, tw: 8};
    iv[8] = '{s: 5, k: 0,  a: 0,  b: 32, tw: 0};
`ifdef FFT_SEQ_BITREV_EN
    lv[0] = '{src: 1,  dst: 32};
    lv[1] = '{src: 6,  dst: 24};
    lv[2] = '{src: 0,  dst: 0};
    lv[3] = '{src: 63, dst: 63};
    lv[4] = '{src: 5,  dst: 40};
`else
    lv[0] = '{src: 1,  dst: 1};
    lv[1] = '{src: 6,  dst: 6};
    lv[2] = '{src: 0,  dst: 0};
    lv[3] = '{src: 63, dst: 63};
    lv[4] = '{src: 5,  dst: 5};
`endif

    rst = 1'b0;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    bus.done_ack = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    rst = 1'b1;

    // Full transform, no hold.
    run_transform(1'b0, 1'b0, busy_cyc, loads, bfs, k10, got_done);
    check("t1 done reached", 32'(got_done), 1);
    check("t1 latency", 32'(busy_cyc), NOM);
    check("t1 load strobes", 32'(loads), N);
    check("t1 bf strobes", 32'(bfs), L * N / 2);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("idx_a s%0d k%0d", iv[i].s, iv[i].k), 32'(rec_a[iv[i].s][iv[i].k]), 32'(iv[i].a));
      check($sformatf("idx_b s%0d k%0d", iv[i].s, iv[i].k), 32'(rec_b[iv[i].s][iv[i].k]), 32'(iv[i].b));
      check($sformatf("tw s%0d k%0d", iv[i].s, iv[i].k), 32'(rec_tw[iv[i].s][iv[i].k]), 32'(iv[i].tw));
    end
    for (int s = 0; s < L; s++) begin
      bad = 0;
      for (int j = 0; j < N; j++) if (seen[s][j] != 1) bad++;
      check($sformatf("stage %0d index coverage", s), 32'(bad), 0);
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("load_dst src %0d", lv[i].src), 32'(ld_dst[lv[i].src]), 32'(lv[i].dst));

    // done holds without ack; a start in DONE is ignored.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      bus.start = (c == 2);
      #1;
      check("done held", 32'(bus.done), 1);
      check("done busy low", 32'(bus.busy), 0);
      check("done no load", 32'(bus.load_en), 0);
    end
    @(posedge clk);
    bus.start = 1'b0;
    ack_done();

    // Hold 3 cycles at s=3,k=10 plus a start pulse mid-RUN.
    run_transform(1'b1, 1'b1, busy_cyc, loads, bfs, k10, got_done);
    check("t2 done reached", 32'(got_done), 1);
    check("t2 latency with hold", 32'(busy_cyc), NOM + 3);
    check("t2 k10 issued once", 32'(k10), 1);
    check("t2 bf strobes", 32'(bfs), L * N / 2);
    check("t2 load strobes", 32'(loads), N);
    ack_done();

    // Asynchronous reset at stage 4, then a fresh full transform.
    @(posedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.stage == 4 && bus.bf_valid) begin
        reached = 1'b1;
        break;
      end
    end
    check("t3 reached stage 4", 32'(reached), 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid reset");
    repeat (2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle after reset", 32'(bus.busy), 0);
    run_transform(1'b0, 1'b0, busy_cyc, loads, bfs, k10, got_done);
    check("t3 done reached", 32'(got_done), 1);
    check("t3 latency", 32'(busy_cyc), NOM);
    check("t3 bf strobes", 32'(bfs), L * N / 2);
    ack_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
